ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-lite responder (slave) backed by an on-chip word-addressed SRAM model. It is the DUT-side counterpart of the bench's master-driving interface. It decodes address/control phases, inserts programmable wait states, performs byte-lane reads and writes, and returns two-cycle ERROR responses for illegal transfers. It sits behind the system decoder; hsel comes from the decoder and hready is the bus-level ready fed back from the mux.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width; 32 or 64 only
MEM_DEPTH, 1024, number of DATA_WIDTH words; byte range is 0 .. MEM_DEPTH*DATA_WIDTH/8-1
WAIT_STATES, 0, hreadyout-low cycles per OKAY data phase; range 0..7

Ports:
hclk  input  1  bus clock; all logic on rising edge
hresetn  input  1  asynchronous, active-low reset
hsel  input  1  slave select from decoder
haddr  input  ADDR_WIDTH  address-phase byte address
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  input  1  1=write, 0=read
hsize  input  3  transfer size, 2**hsize bytes
hburst  input  3  burst type; accepted, not used for address generation
hprot  input  4  protection; ignored
hready  input  1  bus ready; address phase valid only when high
hwdata  input  DATA_WIDTH  write data, valid in data phase
hrdata  output  DATA_WIDTH  read data, registered
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async assert, sync release): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, all captured address/control cleared. Memory contents are not cleared. Reset mid-transfer abandons the transfer; no write is committed.
- Address-phase accept = hsel & hready & htrans[1]. On accept, capture addr, hwrite, hsize, and compute a byte-enable mask from hsize and haddr[log2(DATA_WIDTH/8)-1:0] (little-endian).
- Illegal transfer: byte address beyond memory range, hsize > log2(DATA_WIDTH/8), or haddr not aligned to 2**hsize.
- IDLE/BUSY with hsel, or hsel=0: zero-wait OKAY; no memory access.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on accept of a legal transfer, go to WAIT if WAIT_STATES>0, else remain IDLE with hreadyout=1 next cycle (data phase completes in 1 cycle). On accept of an illegal transfer, go to ERR1.
  - WAIT: hreadyout=0, hresp=0; down-counter from WAIT_STATES. When the count reaches 0, hreadyout=1 (final data cycle), then handle the next accept as in IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1; the next accept is evaluated here. Illegal writes are never committed; illegal reads leave hrdata unchanged.
- Write commit: on the final data-phase edge (hreadyout=1 & OKAY), write hwdata lanes selected by the mask into mem[addr/(DATA_WIDTH/8)].
- Read: hrdata is loaded on the edge that precedes the final data-phase cycle and is held until the next read load. Unselected lanes read back the full stored word.
- Read-after-write hazard: if a read loads hrdata on the same edge a write commits to the same word, hrdata = stored word with the written lanes replaced by hwdata (forwarding).
- The pipeline overlaps: the next address phase is accepted in the final data cycle of the current transfer. A wait state never blocks acceptance of the overlapped address.

Decomposition:
- Package ahb_slave_pkg: htrans_e enum (IDLE/BUSY/NONSEQ/SEQ), hsize constants (BYTE/HALF/WORD/DWORD), HRESP_OKAY/HRESP_ERROR, state_e (IDLE/WAIT/ERR1/ERR2), and a function byte_mask(hsize, addr_lsbs).
- One sub-module: ahb_sram_bytemem, a DEPTH x DATA_WIDTH array with per-byte write enable and one synchronous read port.

Test Plan:
- Write word 0xDEADBEEF at 0x10, then read 0x10 back-to-back (WAIT_STATES=0) -> hrdata=0xDEADBEEF in the read data phase via forwarding; hresp=0 throughout.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10, then word read -> 0xAA223344.
- WAIT_STATES=3, NONSEQ read of 0x0 -> hreadyout low for exactly 3 cycles, then high with valid hrdata; next NONSEQ accepted in that final cycle.
- Read of byte address MEM_DEPTH*4 -> hreadyout=0,hresp=1 then hreadyout=1,hresp=1; hrdata unchanged.
- Misaligned halfword write to 0x1 -> two-cycle ERROR; a subsequent read of 0x0 shows the old data.
- Assert hresetn in the middle of a WAIT-state write -> hreadyout=1, hresp=0, hrdata=0 immediately; a later read shows no write occurred.
- IDLE/BUSY with hsel=1 -> hreadyout=1, hresp=0 every cycle; memory untouched.

Source files
------------

// File: rtl/ahb_slave_pkg.sv
// Shared AHB-lite encodings, FSM states and the little-endian byte-lane mask helper.
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] lsbs);
        logic [7:0] base;
        case (size)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        return base << lsbs;
    endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Word-addressed SRAM with per-byte write enables and one registered read port.
// A read of the word being written on the same edge returns the merged (new) lanes.
module ahb_sram_bytemem #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int NB         = DATA_WIDTH / 8,
    parameter int IW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [NB-1:0]         i_be,
    input  logic [IW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [IW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            for (int b = 0; b < NB; b++) begin
                if (i_we && i_be[b] && (i_waddr == i_raddr))
                    r_rdata[8*b +: 8] <= i_wdata[8*b +: 8];
                else
                    r_rdata[8*b +: 8] <= r_mem[i_raddr][8*b +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder: pipelined address/data phases, programmable wait states,
// byte-lane access and two-cycle ERROR responses for out-of-range/oversized/misaligned transfers.
//   state   | meaning
//   ST_IDLE | no data phase stalled; a zero-wait data phase may be completing
//   ST_WAIT | wait-state countdown; final data cycle once hreadyout returns high
//   ST_ERR1 | first ERROR cycle (hreadyout=0, hresp=1)
//   ST_ERR2 | second ERROR cycle (hreadyout=1, hresp=1); next address evaluated here
module ahb_sram_slave
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int          NB        = DATA_WIDTH / 8;
    localparam int          LSB       = $clog2(NB);
    localparam int          IW        = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [2:0]  CNT_INIT  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e          r_state;
    logic            r_hreadyout;
    logic            r_hresp;
    logic            r_dp_act;
    logic            r_write;
    logic [2:0]      r_cnt;
    logic [IW-1:0]   r_idx;
    logic [NB-1:0]   r_mask;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misalign;
    logic [2:0]      w_lsbs;
    logic [NB-1:0]   w_mask;
    logic [IW-1:0]   w_idx;
    logic            w_we;
    logic            w_rd_fast;
    logic            w_rd_wait;
    logic            w_re;
    logic [IW-1:0]   w_ridx;
    logic            w_unused;

    assign w_accept = hsel & hready & htrans[1];
    assign w_lsbs   = 3'(haddr[LSB-1:0]);
    assign w_mask   = NB'(byte_mask(hsize, w_lsbs));
    assign w_idx    = haddr[LSB +: IW];

    always_comb begin
        case (hsize)
            HSIZE_HALF:  w_misalign = w_lsbs[0];
            HSIZE_WORD:  w_misalign = |w_lsbs[1:0];
            HSIZE_DWORD: w_misalign = |w_lsbs;
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_illegal = (64'(haddr) >= MEM_BYTES) | (hsize > 3'(LSB)) | w_misalign;

    // Zero-wait reads load on the accept edge; waited reads load on the terminal-count edge.
    assign w_we      = r_dp_act & r_write & r_hreadyout;
    assign w_rd_fast = (WAIT_STATES == 0) && r_hreadyout && w_accept && !w_illegal && !hwrite;
    assign w_rd_wait = (r_state == ST_WAIT) && !r_hreadyout && (r_cnt == 3'd0) && r_dp_act && !r_write;
    assign w_re      = w_rd_fast | w_rd_wait;
    assign w_ridx    = w_rd_wait ? r_idx : w_idx;

    assign w_unused  = ^{hburst, hprot, htrans[0]};

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_dp_act    <= 1'b0;
            r_write     <= 1'b0;
            r_cnt       <= 3'd0;
            r_idx       <= '0;
            r_mask      <= '0;
        end else if (r_hreadyout) begin
            r_state  <= ST_IDLE;
            r_hresp  <= HRESP_OKAY;
            r_dp_act <= 1'b0;
            if (w_accept) begin
                if (w_illegal) begin
                    r_state     <= ST_ERR1;
                    r_hreadyout <= 1'b0;
                    r_hresp     <= HRESP_ERROR;
                end else begin
                    r_dp_act <= 1'b1;
                    r_write  <= hwrite;
                    r_idx    <= w_idx;
                    r_mask   <= w_mask;
                    if (WAIT_STATES > 0) begin
                        r_state     <= ST_WAIT;
                        r_hreadyout <= 1'b0;
                        r_cnt       <= CNT_INIT;
                    end
                end
            end
        end else begin
            case (r_state)
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) r_hreadyout <= 1'b1;
                    else               r_cnt       <= r_cnt - 3'd1;
                end
                default: r_hreadyout <= 1'b1;
            endcase
        end
    end

    ahb_sram_bytemem #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .i_clk   (hclk),
        .i_rst_n (hresetn),
        .i_we    (w_we),
        .i_be    (r_mask),
        .i_waddr (r_idx),
        .i_wdata (hwdata),
        .i_re    (w_re),
        .i_raddr (w_ridx),
        .o_rdata (hrdata)
    );

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait instance and a three-wait instance share one master.
module tb_ahb_sram_slave;
    import ahb_slave_pkg::*;

    localparam int WS1 = 3;
    localparam logic [1:0] NS = 2'b10, SQ = 2'b11, ID = 2'b00, BS = 2'b01;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SD = 3'd3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } item_t;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel0 = 1'b0, hsel1 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'b0011;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata0, hrdata1;
    logic        ro0, ro1, rsp0, rsp1;
    logic        hready;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   tgt = 0;
    bit   in_dp = 0;
    int   dp_waits = 0;

    assign hready = ro0 & ro1;
    always #5 hclk = ~hclk;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
        .hwdata(hwdata), .hrdata(hrdata0), .hreadyout(ro0), .hresp(rsp0));

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(WS1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
        .hwdata(hwdata), .hrdata(hrdata1), .hreadyout(ro1), .hresp(rsp1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic item_t mk(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                                 input logic [2:0] sz, input logic [31:0] wd, input logic er,
                                 input logic ck, input logic [31:0] rd);
        item_t it;
        it.sel = 1'b1; it.trans = tr; it.wr = wr; it.addr = a; it.size = sz;
        it.wdata = wd; it.err = er; it.chk = ck; it.rdata = rd;
        return it;
    endfunction

    // Sample at the falling edge and retire the data phase when the bus is ready.
    task automatic sample(output bit rdy);
        exp_t        e;
        logic        rsp;
        logic [31:0] rd;
        @(negedge hclk);
        rdy = hready;
        rsp = (tgt == 1) ? rsp1 : rsp0;
        rd  = (tgt == 1) ? hrdata1 : hrdata0;
        if (in_dp && exp_q.size() > 0) begin
            e = exp_q[0];
            if (!rdy) begin
                dp_waits++;
                check("hresp_stall", {31'd0, rsp}, {31'd0, e.err});
            end else begin
                void'(exp_q.pop_front());
                check("hresp", {31'd0, rsp}, {31'd0, e.err});
                check("wait_cycles", dp_waits, e.waits);
                if (e.chk) check("hrdata", rd, e.rdata);
                in_dp = 0;
                dp_waits = 0;
            end
        end
    endtask

    task automatic drive(input item_t it);
        int n;
        bit rdy;
        int w;
        n = 0;
        hsel0 = it.sel && (tgt == 0);
        hsel1 = it.sel && (tgt == 1);
        haddr = it.addr; htrans = it.trans; hwrite = it.wr; hsize = it.size;
        w = it.err ? 1 : ((it.trans[1] && tgt == 1) ? WS1 : 0);
        if (it.sel) exp_q.push_back('{it.err, it.chk, it.rdata, w});
        do begin
            sample(rdy);
            @(posedge hclk); #1;
            n++;
        end while (!rdy && n < 40);
        if (!rdy) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: hready stayed 0, required 1 within 40 cycles");
        end
        hwdata = it.wdata;
        if (it.sel) begin
            in_dp = 1;
            dp_waits = 0;
        end
    endtask

    task automatic flush();
        item_t it;
        it = mk(ID, 1'b0, 32'h0, SW, 32'h0, 1'b0, 1'b0, 32'h0);
        it.sel = 1'b0;
        drive(it);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t tbl[$];
        item_t seq1[$];

        tbl.push_back(mk(NS, 1, 32'h10,   SW, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(NS, 0, 32'h10,   SW, 32'h0,        0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(NS, 1, 32'h10,   SW, 32'h11223344, 0, 0, 32'h0));
        tbl.push_back(mk(NS, 1, 32'h13,   SB, 32'hAAAAAAAA, 0, 0, 32'h0));
        tbl.push_back(mk(NS, 0, 32'h10,   SW, 32'h0,        0, 1, 32'hAA223344));
        tbl.push_back(mk(NS, 1, 32'h20,   SW, 32'h01020304, 0, 0, 32'h0));
        tbl.push_back(mk(SQ, 1, 32'h22,   SH, 32'hBEEFBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(SQ, 0, 32'h20,   SW, 32'h0,        0, 1, 32'hBEEF0304));
        tbl.push_back(mk(NS, 0, 32'h21,   SB, 32'h0,        0, 1, 32'hBEEF0304));
        tbl.push_back(mk(NS, 1, 32'h0,    SW, 32'hCAFEF00D, 0, 0, 32'h0));
        tbl.push_back(mk(NS, 1, 32'h1,    SH, 32'hFFFFFFFF, 1, 0, 32'h0));
        tbl.push_back(mk(NS, 0, 32'h0,    SW, 32'h0,        0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(NS, 0, 32'h10,   SW, 32'h0,        0, 1, 32'hAA223344));
        tbl.push_back(mk(NS, 0, 32'h1000, SW, 32'h0,        1, 1, 32'hAA223344));
        tbl.push_back(mk(NS, 0, 32'h8,    SD, 32'h0,        1, 1, 32'hAA223344));
        tbl.push_back(mk(ID, 1, 32'h10,   SW, 32'h55555555, 0, 0, 32'h0));
        tbl.push_back(mk(BS, 1, 32'h0,    SW, 32'hFFFFFFFF, 0, 0, 32'h0));
        tbl.push_back(mk(NS, 0, 32'h0,    SW, 32'h0,        0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(NS, 0, 32'h10,   SW, 32'h0,        0, 1, 32'hAA223344));

        seq1.push_back(mk(NS, 1, 32'h0,    SW, 32'h13572468, 0, 0, 32'h0));
        seq1.push_back(mk(NS, 1, 32'h4,    SW, 32'h0BADC0DE, 0, 0, 32'h0));
        seq1.push_back(mk(NS, 0, 32'h0,    SW, 32'h0,        0, 1, 32'h13572468));
        seq1.push_back(mk(NS, 0, 32'h4,    SW, 32'h0,        0, 1, 32'h0BADC0DE));
        seq1.push_back(mk(NS, 1, 32'h8,    SW, 32'hA5A5A5A5, 0, 0, 32'h0));
        seq1.push_back(mk(NS, 0, 32'h8,    SW, 32'h0,        0, 1, 32'hA5A5A5A5));
        seq1.push_back(mk(NS, 0, 32'h1000, SW, 32'h0,        1, 1, 32'hA5A5A5A5));
        seq1.push_back(mk(ID, 0, 32'h0,    SW, 32'h0,        0, 0, 32'h0));

        repeat (2) @(posedge hclk);
        #1;
        check("rst_hreadyout0", {31'd0, ro0}, 32'd1);
        check("rst_hresp0", {31'd0, rsp0}, 32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hreadyout1", {31'd0, ro1}, 32'd1);
        check("rst_hresp1", {31'd0, rsp1}, 32'd0);
        check("rst_hrdata1", hrdata1, 32'd0);
        hresetn = 1'b1;

        tgt = 0;
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
        flush();

        tgt = 1;
        for (int i = 0; i < seq1.size(); i++) drive(seq1[i]);
        flush();

        // Reset lands while the write sits in its wait states.
        drive(mk(NS, 1, 32'h0, SW, 32'hFFFFFFFF, 0, 0, 32'h0));
        check("pre_rst_stall", {31'd0, ro1}, 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        check("mid_rst_hreadyout", {31'd0, ro1}, 32'd1);
        check("mid_rst_hresp", {31'd0, rsp1}, 32'd0);
        check("mid_rst_hrdata", hrdata1, 32'd0);
        exp_q.delete();
        in_dp = 0;
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = ID;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        drive(mk(NS, 0, 32'h0, SW, 32'h0, 0, 1, 32'h13572468));
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
